// File: rtl/multicycle_fsm.sv
// rtl/multicycle_fsm.sv - Moore control FSM for a multicycle MIPS-style datapath
//
// Purpose:
//   Sequences a single-ported, multicycle datapath through fetch, decode and
//   the execute/memory/write-back steps of lw, sw, R-type, beq, addi and j.
//   Memory accesses (fetch, load, store) stall on MemReady.
//
// Ports:
//   CLK        in   1  clock, rising edge
//   RST        in   1  synchronous active-low reset
//   Opcode     in   6  instr[31:26]
//   Funct      in   6  instr[5:0]
//   Zero       in   1  ALU zero flag
//   MemReady   in   1  memory access completes this cycle
//   IorD       out  1  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  1  memory write enable
//   IRWrite    out  1  instruction register load enable
//   PCEn       out  1  PC load enable
//   RegDst     out  1  write register select (0 rt, 1 rd)
//   MemtoReg   out  1  write-back select (0 ALUOut, 1 Data)
//   RegWrite   out  1  register file write enable
//   ALUSrcA    out  1  ALU A select (0 PC, 1 A)
//   ALUSrcB    out  2  ALU B select (B, 4, SignImm, SignImm<<2)
//   PCSrc      out  2  next-PC select (ALUResult, ALUOut, jump target)
//   ALUControl out  3  ALU operation
//   State      out  4  current state encoding
//   Illegal    out  1  unsupported opcode seen in DECODE

module multicycle_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic       pc_write;
  logic       branch;
  logic [1:0] alu_op;

  // State register; reset wins over every transition, including memory stalls.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d  = S_FETCH;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    alu_op   = ALUOP_ADD;
    pc_write = 1'b0;
    branch   = 1'b0;
    Illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every cycle but only committed once the fetch lands.
        ALUSrcB  = 2'b01;
        IRWrite  = MemReady;
        pc_write = MemReady;
        state_d  = MemReady ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target PC+(SignImm<<2) is precomputed into ALUOut here.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        // Write strobe is held for the whole stall so the memory sees a stable request.
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = MemReady ? S_FETCH : S_MEMWR;
      end

      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end

      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end

      // Encodings 12-15 are unreachable; recover to FETCH with everything idle.
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign PCEn = pc_write | (branch & Zero);

  // ALU decoder: ALUOp 11 is unused by the FSM and treated as add.
  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b010;
      ALUOP_SUB: ALUControl = 3'b110;
      ALUOP_FUNCT: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_fsm.sv
// tb/tb_multicycle_fsm.sv - scoreboard bench for multicycle_fsm

module tb_multicycle_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_fsm dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .State(State), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
  } ctl_t;

  typedef struct packed {
    logic [3:0] state;
    ctl_t       ctl;
  } exp_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: an instruction is a list of step codes walked in order.
  int path[$];
  int idx;

  function automatic logic [2:0] funct_op(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit supported(input logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP);
  endfunction

  function automatic exp_t expect_for(input int s, input logic mr, input logic z,
                                      input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e = '0;
    e.state = s[3:0];
    e.ctl.alucontrol = 3'b010;
    case (s)
      0:  begin e.ctl.alusrcb = 2'b01; e.ctl.irwrite = mr; e.ctl.pcen = mr; end
      1:  begin e.ctl.alusrcb = 2'b11; e.ctl.illegal = !supported(op); end
      2:  begin e.ctl.alusrca = 1'b1; e.ctl.alusrcb = 2'b10; end
      3:  e.ctl.iord = 1'b1;
      4:  begin e.ctl.memtoreg = 1'b1; e.ctl.regwrite = 1'b1; end
      5:  begin e.ctl.iord = 1'b1; e.ctl.memwrite = 1'b1; end
      6:  begin e.ctl.alusrca = 1'b1; e.ctl.alucontrol = funct_op(fn); end
      7:  begin e.ctl.regdst = 1'b1; e.ctl.regwrite = 1'b1; end
      8:  begin e.ctl.alusrca = 1'b1; e.ctl.pcsrc = 2'b01; e.ctl.alucontrol = 3'b110; e.ctl.pcen = z; end
      9:  begin e.ctl.alusrca = 1'b1; e.ctl.alusrcb = 2'b10; end
      10: e.ctl.regwrite = 1'b1;
      11: begin e.ctl.pcsrc = 2'b10; e.ctl.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic restart();
    path = '{0, 1};
    idx = 0;
  endtask

  task automatic choose_path(input logic [5:0] op);
    if (op == LW)        path = '{0, 1, 2, 3, 4};
    else if (op == SW)   path = '{0, 1, 2, 5};
    else if (op == RT)   path = '{0, 1, 6, 7};
    else if (op == BEQ)  path = '{0, 1, 8};
    else if (op == ADDI) path = '{0, 1, 9, 10};
    else if (op == JMP)  path = '{0, 1, 11};
    else                 path = '{0, 1};
  endtask

  // One clock of stimulus: drive inputs, record the expected response, step the model.
  task automatic drive_cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic mr);
    int s;
    RST = rst; Opcode = op; Funct = fn; Zero = z; MemReady = mr;
    s = path[idx];
    exp_q.push_back(expect_for(s, mr, z, op, fn));
    if (!rst) begin
      restart();
    end else begin
      if (s == 1) choose_path(op);
      if ((s == 0 || s == 3 || s == 5) && !mr) begin
        // memory stall: stay on this step
      end else begin
        idx++;
        if (idx >= path.size()) restart();
      end
    end
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ctl_t got;
      e = exp_q.pop_front();
      got = '{IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal,
              ALUSrcB, PCSrc, ALUControl};
      checks++;
      if (State === e.state) passed++;
      else $display("FAIL state @%0t: got %0d expected %0d", $time, State, e.state);
      checks++;
      if (got === e.ctl) passed++;
      else $display("FAIL controls @%0t state %0d: got %h expected %h", $time, e.state, got, e.ctl);
    end
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] ops [0:5];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};

    RST = 1'b0;
    @(posedge CLK);
    #1;
    restart();

    // Reset state and a fetch stall.
    drive_cycle(1, LW, 0, 0, 0);
    drive_cycle(1, LW, 0, 0, 0);
    // lw, MemReady tied high: 0,1,2,3,4.
    repeat (5) drive_cycle(1, LW, 0, 0, 1);
    // sw with three stall cycles in MEMWR.
    repeat (3) drive_cycle(1, SW, 0, 0, 1);
    repeat (3) drive_cycle(1, SW, 0, 0, 0);
    drive_cycle(1, SW, 0, 0, 1);
    // R-type slt, and/or.
    repeat (4) drive_cycle(1, RT, 6'b101010, 0, 1);
    repeat (4) drive_cycle(1, RT, 6'b100100, 0, 1);
    repeat (4) drive_cycle(1, RT, 6'b100101, 0, 1);
    // beq taken and not taken.
    repeat (3) drive_cycle(1, BEQ, 0, 1, 1);
    repeat (3) drive_cycle(1, BEQ, 0, 0, 1);
    // Illegal opcode.
    repeat (2) drive_cycle(1, 6'b111111, 0, 0, 1);
    // Reset during a MEMWR stall, then during a MEMRD stall.
    repeat (3) drive_cycle(1, SW, 0, 0, 1);
    drive_cycle(1, SW, 0, 0, 0);
    drive_cycle(0, SW, 0, 0, 0);
    repeat (3) drive_cycle(1, LW, 0, 0, 1);
    drive_cycle(1, LW, 0, 0, 0);
    drive_cycle(0, LW, 0, 0, 0);
    // addi and j.
    repeat (4) drive_cycle(1, ADDI, 0, 0, 1);
    repeat (3) drive_cycle(1, JMP, 0, 1, 1);

    // Randomised traffic; opcode/funct only change while the model sits in FETCH.
    op = LW;
    fn = 6'b100000;
    for (int i = 0; i < 3000; i++) begin
      if (path[idx] == 0) begin
        int pick;
        pick = $urandom_range(0, 7);
        op = (pick < 6) ? ops[pick] : 6'($urandom);
        fn = ($urandom_range(0, 1) == 0) ? 6'($urandom) : (6'b100000 | 6'($urandom_range(0, 10)));
      end
      drive_cycle(($urandom_range(0, 49) != 0), op, fn, 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
